// File: rtl/fir_pkg.sv
// Shared definitions for the FIR correlator: command opcodes, default geometry
// and the coefficient-store state encoding.
package fir_pkg;

    localparam logic [3:0] SET_COEFF     = 4'b0100;
    localparam logic [3:0] CLR_ALL_COEFF = 4'b1000;

    localparam int DEF_CW    = 16;
    localparam int DEF_NTAPS = 16;
    localparam int DEF_AW    = 4;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } coeff_state_t;

endpackage

// File: rtl/fir_coeff_ram.sv
// Coefficient bank: one write port, one registered read-first read port.
// Out-of-range read addresses return zero.
module fir_coeff_ram
    import fir_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int CW    = DEF_CW,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [CW-1:0] rdata
);

    localparam int            IW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [AW:0]   DEPTH = (AW+1)'(NTAPS);

    logic [CW-1:0] mem [NTAPS];

    // NOTE: the bank has no reset; the clear walk is what brings it to a known state.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Both blocks sample mem before the edge updates it, which gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if ({1'b0, raddr} < DEPTH) begin
            rdata <= mem[raddr[IW-1:0]];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/fir_coeff_store.sv
// Coefficient store for the FIR correlator: accepts store/clear strobes from the
// command decoder, walks the bank to zero on clear, serves taps to the MAC.
module fir_coeff_store
    import fir_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int CW    = DEF_CW,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_sto,
    input  logic          c_clr,
    input  logic [AW-1:0] coeff_addr_in,
    input  logic [CW-1:0] coeff_data_in,
    input  logic [AW-1:0] rd_addr,
    output logic [CW-1:0] rd_data,
    output logic          busy,
    output logic          clr_done,
    output logic          sto_drop
);

    localparam logic [AW-1:0] LAST_PTR = AW'(NTAPS - 1);
    localparam logic [AW:0]   DEPTH    = (AW+1)'(NTAPS);

    coeff_state_t  state;
    logic [AW-1:0] clr_ptr;
    logic          clearing;
    logic          sto_ok;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [CW-1:0] ram_wdata;

    // NOTE: combinational decode uses blocking '=' with every output defaulted first,
    // so no latch can be inferred; state below uses '<=' only.
    always_comb begin
        clearing  = (state == CLEARING);
        sto_ok    = c_sto && !clearing && !c_clr && ({1'b0, coeff_addr_in} < DEPTH);
        ram_we    = !rst && (clearing || sto_ok);
        ram_waddr = coeff_addr_in;
        ram_wdata = coeff_data_in;
        if (clearing) begin
            ram_waddr = clr_ptr;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEARING;
            clr_ptr  <= '0;
            busy     <= 1'b1;
            clr_done <= 1'b0;
            sto_drop <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            sto_drop <= c_sto && !sto_ok;
            if (c_clr) begin
                // A clear always restarts the walk from the bottom, even mid-walk.
                state   <= CLEARING;
                clr_ptr <= '0;
                busy    <= 1'b1;
            end else if (state == CLEARING) begin
                if (clr_ptr == LAST_PTR) begin
                    state    <= IDLE;
                    clr_ptr  <= '0;
                    busy     <= 1'b0;
                    clr_done <= 1'b1;
                end else begin
                    clr_ptr <= clr_ptr + 1'b1;
                end
            end
        end
    end

    fir_coeff_ram #(
        .NTAPS (NTAPS),
        .CW    (CW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fir_coeff_store.sv
// Scoreboard bench for fir_coeff_store: a driver feeds directed and random strobes,
// a reference model queues expected outputs, and a monitor compares on the falling edge.
module tb_fir_coeff_store;

    localparam int NTAPS = 16;
    localparam int CW    = 16;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          c_sto = 1'b0;
    logic          c_clr = 1'b0;
    logic [AW-1:0] coeff_addr_in = '0;
    logic [CW-1:0] coeff_data_in = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [CW-1:0] rd_data;
    logic          busy;
    logic          clr_done;
    logic          sto_drop;

    always #5 clk = ~clk;

    fir_coeff_store #(.NTAPS(NTAPS), .CW(CW), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .c_sto         (c_sto),
        .c_clr         (c_clr),
        .coeff_addr_in (coeff_addr_in),
        .coeff_data_in (coeff_data_in),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .clr_done      (clr_done),
        .sto_drop      (sto_drop)
    );

    typedef struct {
        logic [CW-1:0] rd;
        bit            chk_rd;
        bit            busy;
        bit            done;
        bit            drop;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the bank is zeroed the moment a clear is accepted and a
    // countdown tracks how long the store stays unavailable; reads are only
    // trusted when the bank was not busy at the sampling edge.
    logic [CW-1:0] ref_mem [NTAPS];
    bit            m_busy = 1'b1;
    int            m_left = NTAPS;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_edge(output exp_t e);
        bit accept;
        e.rd     = '0;
        e.chk_rd = 1'b1;
        e.done   = 1'b0;
        e.drop   = 1'b0;
        if (rst) begin
            m_busy = 1'b1;
            m_left = NTAPS;
            foreach (ref_mem[i]) ref_mem[i] = '0;
        end else begin
            if (int'(rd_addr) < NTAPS) e.rd = ref_mem[int'(rd_addr)];
            e.chk_rd = !m_busy;
            accept = c_sto && !m_busy && !c_clr && (int'(coeff_addr_in) < NTAPS);
            e.drop = c_sto && !accept;
            if (c_clr) begin
                m_busy = 1'b1;
                m_left = NTAPS;
                foreach (ref_mem[i]) ref_mem[i] = '0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    e.done = 1'b1;
                end
            end
            if (accept) ref_mem[int'(coeff_addr_in)] = coeff_data_in;
        end
        e.busy = m_busy;
    endtask

    task automatic step(input logic r, input logic s, input logic cl,
                        input int a, input int d, input int ra);
        exp_t e;
        rst           = r;
        c_sto         = s;
        c_clr         = cl;
        coeff_addr_in = AW'(a);
        coeff_data_in = CW'(d);
        rd_addr       = AW'(ra);
        @(posedge clk);
        model_edge(e);
        sb.push_back(e);
        #1;
    endtask

    task automatic idle(input int n, input int ra);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, ra);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.chk_rd) check("rd_data", 32'(rd_data), 32'(e.rd));
            check("busy", 32'(busy), 32'(e.busy));
            check("clr_done", 32'(clr_done), 32'(e.done));
            check("sto_drop", 32'(sto_drop), 32'(e.drop));
        end
    end

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = '0;

        // Reset, then the power-up walk, then read every tap.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(18, 0);
        for (int i = 0; i < NTAPS; i++) step(1'b0, 1'b0, 1'b0, 0, 0, i);

        // Store then read back; same-cycle read sees the old value.
        step(1'b0, 1'b1, 1'b0, 3, 16'h1234, 3);
        idle(2, 3);

        // Store, clear, store while busy is dropped; both taps read zero after the walk.
        step(1'b0, 1'b1, 1'b0, 5, 16'hBEEF, 0);
        idle(1, 5);
        step(1'b0, 1'b0, 1'b1, 0, 0, 5);
        step(1'b0, 1'b1, 1'b0, 7, 16'h0055, 7);
        idle(17, 5);
        idle(1, 7);

        // Out-of-range store, then store colliding with clear.
        step(1'b0, 1'b1, 1'b0, 20, 16'hAAAA, 20);
        step(1'b0, 1'b1, 1'b0, 9, 16'h9999, 9);
        idle(1, 9);
        step(1'b0, 1'b1, 1'b1, 9, 16'h7777, 9);
        idle(18, 9);

        // Clear restarted mid-walk.
        step(1'b0, 1'b0, 1'b1, 0, 0, 0);
        idle(8, 0);
        step(1'b0, 1'b0, 1'b1, 0, 0, 0);
        idle(18, 0);

        // Reset mid-walk, then a full walk; tap 15 reads zero afterwards.
        step(1'b0, 1'b1, 1'b0, 15, 16'hF00D, 15);
        step(1'b0, 1'b0, 1'b1, 0, 0, 15);
        idle(5, 15);
        step(1'b1, 1'b0, 1'b0, 0, 0, 15);
        step(1'b1, 1'b0, 1'b0, 0, 0, 15);
        idle(18, 15);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            logic r, s, cl;
            int   a, ra;
            r  = ($urandom_range(0, 249) == 0);
            cl = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            step(r, s, cl, a, int'($urandom_range(0, 65535)), ra);
        end
        idle(20, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
